// File: rtl/i2c_pkg.sv
// Shared types and helpers for the single-byte I2C master controller.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP
  } i2c_state_e;

  typedef enum logic [1:0] {
    P0,
    P1,
    P2,
    P3
  } i2c_phase_e;

  localparam int I2C_BITS_FULL = 20;
  localparam int I2C_BITS_NACK = 11;

  // {scl, sda} for one bus position; b is the data bit of a shifted bit
  function automatic logic [1:0] bus_drive(
    input i2c_state_e s,
    input i2c_phase_e p,
    input logic       b
  );
    logic       hi;
    logic [1:0] d;
    hi = (p == P2) || (p == P3);
    unique case (s)
      IDLE:    d = 2'b11;
      START:   d = {1'b1, ~hi};
      STOP:    d = {p != P0, p == P3};
      default: d = {hi, b};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// Request-side handshake bundle for the I2C master controller.
interface i2c_master_ctrl_if;

  logic       req;
  logic       ready;
  logic [6:0] addr;
  logic       wr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       done;
  logic       ack_err;
  logic       busy;

  modport master (
    output req, addr, wr, din,
    input  ready, dout, done, ack_err, busy
  );

  modport slave (
    input  req, addr, wr, din,
    output ready, dout, done, ack_err, busy
  );

endinterface

// File: rtl/i2c_bit_timer.sv
// Clock divider and quarter-period phase counter for one I2C bit.
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       tick,
  output i2c_phase_e phase,
  output logic       bit_end,
  output logic       pre_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick    = en && (cnt == CW'(CLK_DIV - 1));
  assign bit_end = tick && (phase == P3);
  // one cycle ahead of bit_end, lets registered outputs hit the last cycle
  assign pre_end = en && (phase == P3)
                && (cnt == CW'(CLK_DIV - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= P0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= P0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= i2c_phase_e'(phase + 2'd1);
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, addr+R/W, ACK, data, ACK/NACK, STOP.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  i2c_master_ctrl_if.slave bus,
  output logic             scl,
  output logic             sda_o,
  input  logic             sda_i
);

  i2c_state_e state, state_n;
  i2c_phase_e phase, phase_n;

  logic       tick, bit_end, pre_end;
  logic       en, accept, sample, fin;
  logic [2:0] bit_cnt;
  logic [7:0] sreg, sreg_n;
  logic [7:0] din_q, rx, dout_q;
  logic       wr_q, ready_q, busy_q;
  logic       done_q, err_q, drv_bit;
  logic [1:0] drv_n;

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .tick    (tick),
    .phase   (phase),
    .bit_end (bit_end),
    .pre_end (pre_end)
  );

  assign en     = state != IDLE;
  assign accept = bus.req && ready_q;
  assign sample = tick && (phase == P2);
  assign fin    = (state == STOP) && pre_end;

  assign bus.ready   = ready_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ack_err = err_q;
  assign bus.dout    = dout_q;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: ;
      START:
        if (bit_end) state_n = ADDR;
      ADDR:
        if (bit_end && bit_cnt == 3'd0)
          state_n = ADDR_ACK;
      ADDR_ACK:
        if (bit_end)
          state_n = err_q ? STOP : DATA;
      DATA:
        if (bit_end && bit_cnt == 3'd0)
          state_n = DATA_ACK;
      DATA_ACK:
        if (bit_end) state_n = STOP;
      STOP:
        if (bit_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (accept) state_n = START;
  end

  // Pins are registered from the next bus position, so every
  // scl/sda change lands on the first cycle of its phase.
  always_comb begin
    phase_n = tick ? i2c_phase_e'(phase + 2'd1)
                   : phase;
    sreg_n  = sreg;
    if (accept) begin
      sreg_n = {bus.addr, ~bus.wr};
    end else if (bit_end) begin
      unique case (1'b1)
        state == ADDR,
        state == DATA:     sreg_n = {sreg[6:0], 1'b0};
        state == ADDR_ACK: sreg_n = din_q;
        default: ;
      endcase
    end
    drv_bit = 1'b1;
    if (state_n == ADDR
        || (state_n == DATA && wr_q))
      drv_bit = sreg_n[7];
    drv_n = bus_drive(state_n, phase_n, drv_bit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      bit_cnt <= 3'd7;
      din_q   <= '0;
      wr_q    <= 1'b0;
      rx      <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      scl     <= 1'b1;
      sda_o   <= 1'b1;
    end else begin
      sreg         <= sreg_n;
      {scl, sda_o} <= drv_n;
      done_q       <= fin;
      if (accept) begin
        wr_q    <= bus.wr;
        din_q   <= bus.din;
        err_q   <= 1'b0;
        ready_q <= 1'b0;
        busy_q  <= 1'b1;
      end else if (fin) begin
        ready_q <= 1'b1;
        busy_q  <= 1'b0;
      end
      if (bit_end && (state == ADDR || state == DATA))
        bit_cnt <= bit_cnt - 3'd1;
      if (sample) begin
        if (state == ADDR_ACK && sda_i)
          err_q <= 1'b1;
        if (state == DATA_ACK && wr_q && sda_i)
          err_q <= 1'b1;
        if (state == DATA && !wr_q)
          rx <= {rx[6:0], sda_i};
      end
      if (bit_end && state == DATA_ACK && !wr_q)
        dout_q <= rx;
    end
  end

endmodule
